// File: rtl/w5300_pkg.sv
// -----------------------------------------------------------------------------
// w5300_pkg
// Shared definitions for the W5300 register-access sequencer: LUT entry layout
// {op, addr[9:0], value[15:0]}, op encodings, phase-counter width, the
// sequencer state encoding, and field-extraction helpers for LUT entries.
// -----------------------------------------------------------------------------
package w5300_pkg;

   localparam int LUT_W    = 27;
   localparam int OP_BIT   = 26;
   localparam int ADDR_HI  = 25;
   localparam int ADDR_LO  = 16;
   localparam int VALUE_HI = 15;
   localparam int VALUE_LO = 0;
   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 16;

   // Width of the shared phase down-counter; phases up to 256 clocks.
   localparam int CNT_W    = 8;

   localparam logic OP_READ  = 1'b1;
   localparam logic OP_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LATCH   = 3'd1,
      ST_SETUP   = 3'd2,
      ST_STROBE  = 3'd3,
      ST_RECOVER = 3'd4,
      ST_FINISH  = 3'd5
   } seq_state_t;

   function automatic logic lut_op(input logic [LUT_W-1:0] entry);
      return entry[OP_BIT];
   endfunction

   function automatic logic [ADDR_W-1:0] lut_addr(input logic [LUT_W-1:0] entry);
      return entry[ADDR_HI:ADDR_LO];
   endfunction

   function automatic logic [DATA_W-1:0] lut_value(input logic [LUT_W-1:0] entry);
      return entry[VALUE_HI:VALUE_LO];
   endfunction

endpackage

// File: rtl/w5300_lut_sequencer_if.sv
// -----------------------------------------------------------------------------
// w5300_lut_sequencer_if
// W5300 parallel host-bus pins as seen from the core side (tristate pads live
// above this level).
//   w_addr  ADDR[9:0]           w_dout  write data to pad
//   w_din   read data from pad  w_doe   pad output enable
//   w_cs_n  chip select (low)   w_rd_n / w_wr_n  strobes (low)
// master: the sequencer; slave: the device / pad side.
// -----------------------------------------------------------------------------
interface w5300_lut_sequencer_if;
   import w5300_pkg::*;

   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_dout;
   logic [DATA_W-1:0] w_din;
   logic              w_doe;
   logic              w_cs_n;
   logic              w_rd_n;
   logic              w_wr_n;

   modport master (
      output w_addr, w_dout, w_doe, w_cs_n, w_rd_n, w_wr_n,
      input  w_din
   );

   modport slave (
      input  w_addr, w_dout, w_doe, w_cs_n, w_rd_n, w_wr_n,
      output w_din
   );

endinterface

// File: rtl/w5300_bus_timer.sv
// -----------------------------------------------------------------------------
// w5300_bus_timer
// Down-counter shared by the SETUP / STROBE / RECOVER phases. Loading N-1
// makes zero rise after N clocks in the phase.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val this clock (takes priority over counting)
//   load_val    reload value
//   zero        count has reached zero (holds there)
// -----------------------------------------------------------------------------
module w5300_bus_timer
   import w5300_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/w5300_lut_sequencer.sv
// -----------------------------------------------------------------------------
// w5300_lut_sequencer
// Walks LUT entries 0..last_index and turns each {op, addr, value} entry into
// one timed W5300 bus cycle: LATCH, SETUP, STROBE, RECOVER. Read results are
// reported upstream with a one-cycle rd_valid pulse.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin a sequence (ignored while busy)
//   last_index   final entry, captured on accepted start
//   abort        stop after the access in flight completes
//   lut_index    LUT address; lut_data returns the entry in the same cycle
//   busy/done/aborted  sequence status; done pulses once per sequence
//   rd_valid/rd_addr/rd_data  captured read result
//   bus          W5300 pin bundle (master side)
// -----------------------------------------------------------------------------
module w5300_lut_sequencer
   import w5300_pkg::*;
#(
   parameter int INDEX_W        = 6,
   parameter int SETUP_CYCLES   = 1,
   parameter int STROBE_CYCLES  = 7,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [INDEX_W-1:0]    last_index,
   input  logic                  abort,
   output logic [INDEX_W-1:0]    lut_index,
   input  logic [LUT_W-1:0]      lut_data,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  rd_valid,
   output logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   w5300_lut_sequencer_if.master bus
);

   localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYCLES - 1);

   seq_state_t         state;
   logic [INDEX_W-1:0] last_q;
   logic               op_q;
   logic               abort_seen;

   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_val;
   logic               tmr_zero;

   w5300_bus_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // The timer is reloaded in the last clock of the preceding phase so its
   // count lines up with the first clock of the next phase.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_LATCH: begin
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
         end
         ST_SETUP: begin
            tmr_load = tmr_zero;
            tmr_val  = STROBE_LD;
         end
         ST_STROBE: begin
            tmr_load = tmr_zero;
            tmr_val  = RECOVER_LD;
         end
         default: begin
            tmr_load = 1'b0;
            tmr_val  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         last_q      <= '0;
         op_q        <= OP_WRITE;
         abort_seen  <= 1'b0;
         lut_index   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         rd_valid    <= 1'b0;
         rd_addr     <= '0;
         rd_data     <= '0;
         bus.w_addr  <= '0;
         bus.w_dout  <= '0;
         bus.w_doe   <= 1'b0;
         bus.w_cs_n  <= 1'b1;
         bus.w_rd_n  <= 1'b1;
         bus.w_wr_n  <= 1'b1;
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;

         // Abort is remembered for the rest of the sequence; it only takes
         // effect at an access boundary so a strobe is never cut short.
         if (state != ST_IDLE && abort) begin
            abort_seen <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  lut_index <= '0;
                  last_q    <= last_index;
                  busy      <= 1'b1;
                  state     <= ST_LATCH;
               end
            end

            ST_LATCH: begin
               op_q       <= lut_op(lut_data);
               bus.w_addr <= lut_addr(lut_data);
               bus.w_dout <= lut_value(lut_data);
               bus.w_doe  <= (lut_op(lut_data) == OP_WRITE);
               bus.w_cs_n <= 1'b0;
               state      <= ST_SETUP;
            end

            ST_SETUP: begin
               if (tmr_zero) begin
                  bus.w_rd_n <= (op_q != OP_READ);
                  bus.w_wr_n <= (op_q != OP_WRITE);
                  state      <= ST_STROBE;
               end
            end

            ST_STROBE: begin
               if (tmr_zero) begin
                  // Sample on the same edge the strobe rises: the pad data
                  // is still driven by the device through the strobe.
                  bus.w_rd_n <= 1'b1;
                  bus.w_wr_n <= 1'b1;
                  if (op_q == OP_READ) begin
                     rd_valid <= 1'b1;
                     rd_addr  <= bus.w_addr;
                     rd_data  <= bus.w_din;
                  end
                  state <= ST_RECOVER;
               end
            end

            ST_RECOVER: begin
               // Address and write data stay put; only cs_n and the pad
               // enable drop, one clock after the strobe rise.
               bus.w_cs_n <= 1'b1;
               bus.w_doe  <= 1'b0;
               if (tmr_zero) begin
                  if (abort_seen || abort || lut_index == last_q) begin
                     done    <= 1'b1;
                     aborted <= abort_seen || abort;
                     state   <= ST_FINISH;
                  end else begin
                     lut_index <= lut_index + INDEX_W'(1);
                     state     <= ST_LATCH;
                  end
               end
            end

            ST_FINISH: begin
               busy       <= 1'b0;
               abort_seen <= 1'b0;
               state      <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
